// File: rtl/phy_rx_align_ctrl_pkg.sv
// Shared definitions for the receive word-alignment controller.
// Holds the FSM state encoding, the comma character and the mapping from
// lane_phase to the deserializer slot that phase writes.
package phy_rx_align_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_SYNC    = 2'd2
    } align_state_t;

    localparam logic [7:0] COMMA_BC   = 8'hBC;
    localparam logic [1:0] PHASE_LAST = 2'd3;

    // Bit index of the low bit of the slot written in a given phase:
    // 0 -> [7:6], 1 -> [5:4], 2 -> [3:2], 3 -> [1:0].
    function automatic logic [2:0] slot_lsb(input logic [1:0] phase);
        return 3'd6 - {phase, 1'b0};
    endfunction

endpackage

// File: rtl/phy_rx_phase_gen.sv
// Slot-phase sequencer for the deserializer.
// Runs lane_phase 0,1,2,3,0... continuously. A slip request raised on a word
// boundary holds phase 3 for one extra cycle (slip_o=1), so slot [1:0] is
// written twice and the word alignment moves by one bit-pair.
// Ports:
//   clk16, reset16  : clock, synchronous active-high reset
//   slip_req_i      : request a phase hold; honoured only on a word boundary
//   lane_phase_o    : current slot select
//   slip_o          : high during the hold cycle
//   word_bdry_o     : word boundary (phase 3 and not a hold cycle)
module phy_rx_phase_gen
    import phy_rx_align_ctrl_pkg::*;
(
    input  logic       clk16,
    input  logic       reset16,
    input  logic       slip_req_i,
    output logic [1:0] lane_phase_o,
    output logic       slip_o,
    output logic       word_bdry_o
);

    logic [1:0] phase_q, phase_d;
    logic       slip_q, slip_d;
    logic       word_bdry;

    assign word_bdry = (phase_q == PHASE_LAST) && !slip_q;

    always_comb begin
        phase_d = phase_q + 2'd1;
        slip_d  = 1'b0;
        if (slip_q) begin
            phase_d = 2'd0;
        end else if (word_bdry && slip_req_i) begin
            phase_d = phase_q;
            slip_d  = 1'b1;
        end
    end

    always_ff @(posedge clk16) begin
        if (reset16) begin
            phase_q <= 2'd0;
            slip_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            slip_q  <= slip_d;
        end
    end

    assign lane_phase_o = phase_q;
    assign slip_o       = slip_q;
    assign word_bdry_o  = word_bdry;

endmodule

// File: rtl/phy_rx_align_ctrl.sv
// Word-alignment and link-sync controller for the receive deserializer.
// Hunts for COMMA on word boundaries, slipping the slot phase after
// HUNT_TIMEOUT misses, declares sync after ACQ_COUNT consecutive commas and
// then forwards non-comma words. Sync is lost after MAX_GAP comma-free words
// or on a resync request.
// Output handshake: out_valid is a one-cycle strobe qualifying out_data; there
// is no back-pressure, the consumer must take the word in that cycle.
// Ports:
//   clk16, reset16 : clock, synchronous active-high reset
//   word_in        : assembled word, sampled on word-boundary edges only
//   resync         : one-cycle request to drop sync and restart hunting
//   lane_phase     : slot select to the deserializer
//   slip           : phase-hold cycle indicator
//   sync_ok        : high while in SYNC
//   out_data       : last non-comma word received in SYNC
//   out_valid      : one-cycle strobe with each out_data update
//   sync_loss_cnt  : saturating count of SYNC->HUNT transitions
//   dbg_state      : FSM state for debug visibility
module phy_rx_align_ctrl
    import phy_rx_align_ctrl_pkg::*;
#(
    parameter logic [7:0] COMMA        = COMMA_BC,
    parameter int         ACQ_COUNT    = 4,
    parameter int         HUNT_TIMEOUT = 8,
    parameter int         MAX_GAP      = 64
) (
    input  logic       clk16,
    input  logic       reset16,
    input  logic [7:0] word_in,
    input  logic       resync,
    output logic [1:0] lane_phase,
    output logic       slip,
    output logic       sync_ok,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic [7:0] sync_loss_cnt,
    output logic [1:0] dbg_state
);

    align_state_t state_q, state_d;
    logic [7:0]   miss_q, miss_d;
    logic [3:0]   good_q, good_d;
    logic [7:0]   gap_q, gap_d;
    logic [7:0]   out_data_q, out_data_d;
    logic         out_valid_q, out_valid_d;
    logic [7:0]   loss_q, loss_d;
    logic         slip_req;
    logic         word_bdry;
    logic         is_comma;

    phy_rx_phase_gen u_phase_gen (
        .clk16        (clk16),
        .reset16      (reset16),
        .slip_req_i   (slip_req),
        .lane_phase_o (lane_phase),
        .slip_o       (slip),
        .word_bdry_o  (word_bdry)
    );

    assign is_comma = (word_in == COMMA);

    always_comb begin
        state_d     = state_q;
        miss_d      = miss_q;
        good_d      = good_q;
        gap_d       = gap_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        loss_d      = loss_q;
        slip_req    = 1'b0;

        if (resync) begin
            // Takes priority over the boundary decision, so no slip is requested.
            state_d = ST_HUNT;
            miss_d  = 8'd0;
            good_d  = 4'd0;
            gap_d   = 8'd0;
            if (state_q == ST_SYNC && loss_q != 8'hFF) loss_d = loss_q + 8'd1;
        end else if (word_bdry) begin
            unique case (state_q)
                ST_HUNT: begin
                    if (is_comma) begin
                        good_d = 4'd1;
                        miss_d = 8'd0;
                        if (ACQ_COUNT == 1) begin
                            state_d = ST_SYNC;
                            gap_d   = 8'd0;
                        end else begin
                            state_d = ST_ACQUIRE;
                        end
                    end else if (miss_q + 8'd1 == 8'(HUNT_TIMEOUT)) begin
                        slip_req = 1'b1;
                        miss_d   = 8'd0;
                    end else begin
                        miss_d = miss_q + 8'd1;
                    end
                end
                ST_ACQUIRE: begin
                    if (is_comma) begin
                        good_d = good_q + 4'd1;
                        if (good_q + 4'd1 == 4'(ACQ_COUNT)) begin
                            state_d = ST_SYNC;
                            gap_d   = 8'd0;
                        end
                    end else begin
                        state_d = ST_HUNT;
                        good_d  = 4'd0;
                    end
                end
                ST_SYNC: begin
                    if (is_comma) begin
                        gap_d = 8'd0;
                    end else begin
                        // The word that exhausts the gap budget is still forwarded.
                        out_data_d  = word_in;
                        out_valid_d = 1'b1;
                        gap_d       = gap_q + 8'd1;
                        if (gap_q + 8'd1 == 8'(MAX_GAP)) begin
                            state_d = ST_HUNT;
                            gap_d   = 8'd0;
                            if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
                        end
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end
    end

    always_ff @(posedge clk16) begin
        if (reset16) begin
            state_q     <= ST_HUNT;
            miss_q      <= 8'd0;
            good_q      <= 4'd0;
            gap_q       <= 8'd0;
            out_data_q  <= 8'd0;
            out_valid_q <= 1'b0;
            loss_q      <= 8'd0;
        end else begin
            state_q     <= state_d;
            miss_q      <= miss_d;
            good_q      <= good_d;
            gap_q       <= gap_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            loss_q      <= loss_d;
        end
    end

    assign sync_ok       = (state_q == ST_SYNC);
    assign out_data      = out_data_q;
    assign out_valid     = out_valid_q;
    assign sync_loss_cnt = loss_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_phy_rx_align_ctrl.sv
module tb_phy_rx_align_ctrl;

    localparam logic [7:0] BC = 8'hBC;
    localparam int ACQ = 4;
    localparam int HTO = 8;
    localparam int GAP = 64;
    localparam int M_HUNT = 0;
    localparam int M_ACQ  = 1;
    localparam int M_SYNC = 2;

    // clock / reset / DUT
    logic       clk16 = 1'b0;
    logic       reset16 = 1'b1;
    logic [7:0] word_in = 8'd0;
    logic       resync = 1'b0;
    logic [1:0] lane_phase;
    logic       slip;
    logic       sync_ok;
    logic [7:0] out_data;
    logic       out_valid;
    logic [7:0] sync_loss_cnt;
    logic [1:0] dbg_state;

    always #5 clk16 = ~clk16;

    phy_rx_align_ctrl dut (
        .clk16         (clk16),
        .reset16       (reset16),
        .word_in       (word_in),
        .resync        (resync),
        .lane_phase    (lane_phase),
        .slip          (slip),
        .sync_ok       (sync_ok),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .sync_loss_cnt (sync_loss_cnt),
        .dbg_state     (dbg_state)
    );

    // scoreboard
    logic [7:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    bit mon_en = 1'b0;

    // reference model: what the link should look like after each edge
    int         m_phase, m_state, m_miss, m_good, m_gap, m_loss;
    bit         m_slip, m_valid;
    logic [7:0] m_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] nc();
        logic [7:0] v;
        do v = 8'($urandom); while (v == BC);
        return v;
    endfunction

    function automatic bit at_w();
        return (m_phase == 3) && !m_slip;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_slip = 0; m_state = M_HUNT; m_miss = 0; m_good = 0;
        m_gap = 0; m_loss = 0; m_valid = 0; m_data = 8'd0;
    endtask

    // Drive one cycle: apply inputs, advance the model across the edge.
    task automatic step(input logic [7:0] w, input logic rs, input logic rst);
        bit wb, do_slip;
        word_in = w;
        resync  = rs;
        reset16 = rst;
        @(posedge clk16);
        wb = at_w();
        do_slip = 0;
        m_valid = 0;
        if (rst) begin
            model_reset();
        end else begin
            if (rs) begin
                if (m_state == M_SYNC && m_loss < 255) m_loss++;
                m_state = M_HUNT; m_miss = 0; m_good = 0; m_gap = 0;
            end else if (wb) begin
                if (m_state == M_HUNT) begin
                    if (w == BC) begin
                        m_good = 1; m_miss = 0;
                        m_state = (ACQ == 1) ? M_SYNC : M_ACQ;
                        m_gap = 0;
                    end else begin
                        m_miss++;
                        if (m_miss == HTO) begin do_slip = 1; m_miss = 0; end
                    end
                end else if (m_state == M_ACQ) begin
                    if (w == BC) begin
                        m_good++;
                        if (m_good == ACQ) begin m_state = M_SYNC; m_gap = 0; end
                    end else begin
                        m_state = M_HUNT; m_good = 0;
                    end
                end else begin
                    if (w == BC) begin
                        m_gap = 0;
                    end else begin
                        m_data = w; m_valid = 1; exp_q.push_back(w);
                        m_gap++;
                        if (m_gap == GAP) begin
                            m_state = M_HUNT; m_gap = 0;
                            if (m_loss < 255) m_loss++;
                        end
                    end
                end
            end
            if (m_slip) begin m_phase = 0; m_slip = 0; end
            else if (wb && do_slip) begin m_phase = 3; m_slip = 1; end
            else m_phase = (m_phase + 1) % 4;
        end
        @(negedge clk16);
    endtask

    // Junk on non-boundary cycles, then the real word on the boundary.
    task automatic send_word(input logic [7:0] w, input logic rs);
        while (!at_w()) step(8'($urandom), 1'b0, 1'b0);
        step(w, rs, 1'b0);
    endtask

    task automatic do_reset();
        step(8'd0, 1'b0, 1'b1);
        step(8'd0, 1'b0, 1'b1);
    endtask

    // monitor: per-cycle output check plus scoreboard pop on every strobe
    always @(negedge clk16) begin
        if (mon_en) begin
            chk("lane_phase", 32'(lane_phase), 32'(m_phase));
            chk("slip", 32'(slip), 32'(m_slip));
            chk("sync_ok", 32'(sync_ok), 32'(m_state == M_SYNC));
            chk("state", 32'(dbg_state), 32'(m_state));
            chk("loss_cnt", 32'(sync_loss_cnt), 32'(m_loss));
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            chk("out_data_hold", 32'(out_data), 32'(m_data));
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) chk("unexpected_valid", 32'(out_data), 32'hFFFF_FFFF);
                else chk("sb_data", 32'(out_data), 32'(exp_q.pop_front()));
            end
        end
    end

    int slips_seen;
    always @(negedge clk16) if (mon_en && slip === 1'b1) slips_seen++;

    initial begin
        model_reset();
        slips_seen = 0;
        @(negedge clk16);
        do_reset();
        mon_en = 1'b1;
        chk("rst_phase", 32'(lane_phase), 32'd0);
        chk("rst_sync", 32'(sync_ok), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_loss", 32'(sync_loss_cnt), 32'd0);

        // aligned link
        for (int i = 0; i < 4; i++) send_word(BC, 1'b0);
        chk("aligned_sync", 32'(sync_ok), 32'd1);
        send_word(8'h5A, 1'b0);
        chk("aligned_valid", 32'(out_valid), 32'd1);
        chk("aligned_data", 32'(out_data), 32'h5A);

        // misaligned: constant 00 slips every 8 words
        do_reset();
        slips_seen = 0;
        for (int i = 0; i < 20; i++) send_word(8'h00, 1'b0);
        chk("misalign_slips", 32'(slips_seen), 32'd2);
        chk("misalign_sync", 32'(sync_ok), 32'd0);

        // broken acquire
        do_reset();
        slips_seen = 0;
        send_word(BC, 1'b0); send_word(BC, 1'b0); send_word(8'h00, 1'b0);
        chk("broken_hunt", 32'(dbg_state), 32'(M_HUNT));
        send_word(BC, 1'b0);
        chk("broken_acq", 32'(dbg_state), 32'(M_ACQ));
        chk("broken_noslip", 32'(slips_seen), 32'd0);

        // gap loss and relock
        do_reset();
        for (int i = 0; i < 4; i++) send_word(BC, 1'b0);
        for (int i = 0; i < GAP; i++) send_word(nc(), 1'b0);
        chk("gap_lost", 32'(sync_ok), 32'd0);
        chk("gap_loss_cnt", 32'(sync_loss_cnt), 32'd1);
        for (int i = 0; i < 4; i++) send_word(BC, 1'b0);
        chk("gap_relock", 32'(sync_ok), 32'd1);

        // resync in ACQUIRE on a comma boundary, then in SYNC
        do_reset();
        send_word(BC, 1'b0); send_word(BC, 1'b0);
        send_word(BC, 1'b1);
        chk("resync_acq_state", 32'(dbg_state), 32'(M_HUNT));
        chk("resync_acq_loss", 32'(sync_loss_cnt), 32'd0);
        for (int i = 0; i < 4; i++) send_word(BC, 1'b0);
        send_word(8'h33, 1'b1);
        chk("resync_sync_loss", 32'(sync_loss_cnt), 32'd1);
        chk("resync_sync_valid", 32'(out_valid), 32'd0);

        // reset while a strobe is out
        for (int i = 0; i < 4; i++) send_word(BC, 1'b0);
        send_word(8'hA5, 1'b0);
        chk("midrst_pre_valid", 32'(out_valid), 32'd1);
        step(8'h00, 1'b0, 1'b1);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_data", 32'(out_data), 32'd0);
        chk("midrst_phase", 32'(lane_phase), 32'd0);
        chk("midrst_sync", 32'(sync_ok), 32'd0);

        // random traffic with runs of commas and data, rare resync/reset
        for (int i = 0; i < 700; i++) begin
            bit comma_run;
            comma_run = ((i / 12) % 2) == 0;
            if ($urandom_range(0, 249) == 0) step(8'($urandom), 1'b0, 1'b1);
            else if (comma_run && $urandom_range(0, 9) != 0) send_word(BC, $urandom_range(0, 59) == 0);
            else send_word(nc(), $urandom_range(0, 59) == 0);
        end
        step(8'd0, 1'b0, 1'b0);
        step(8'd0, 1'b0, 1'b0);
        mon_en = 1'b0;
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
